// File: rtl/asteroid_pkg.sv
// rtl/asteroid_pkg.sv - shared types and constants for the asteroid wave controller
package asteroid_pkg;

    localparam int COORD_W = 10;
    localparam int LFSR_W  = 16;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        SPAWN
    } state_e;

    typedef struct packed {
        logic                      active;
        logic [COORD_W-1:0]        x;
        logic [COORD_W-1:0]        y;
        logic signed [2:0]         hspd;
        logic [2:0]                vspd;
    } slot_t;

endpackage

// File: rtl/asteroid_wave_ctrl_lfsr16.sv
// rtl/asteroid_wave_ctrl_lfsr16.sv - 16-bit Fibonacci LFSR with clock enable
module lfsr16
    import asteroid_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/asteroid_wave_ctrl.sv
// rtl/asteroid_wave_ctrl.sv - per-frame asteroid slot scheduler with spawn and retire logic
module asteroid_wave_ctrl
    import asteroid_pkg::*;
#(
    parameter int                N_AST     = 4,
    parameter int                XMIN      = 10,
    parameter int                XMAX      = 610,
    parameter int                YSPAWN    = 10,
    parameter int                YEXIT     = 480,
    parameter int                SPAWN_GAP = 30,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pixpulse,
    input  logic                       frame_tick,
    input  logic                       enable,
    input  logic [N_AST-1:0]           hit,
    output logic [N_AST-1:0]           active,
    output logic [COORD_W*N_AST-1:0]   xloc,
    output logic [COORD_W*N_AST-1:0]   yloc,
    output logic                       score_inc,
    output logic                       kill_inc,
    output logic                       overrun
);

    localparam int IDX_W = (N_AST > 1) ? $clog2(N_AST) : 1;
    localparam int CNT_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_AST - 1);
    localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(SPAWN_GAP - 1);
    localparam logic signed [10:0]  XMIN_S   = 11'(XMIN);
    localparam logic signed [10:0]  XMAX_S   = 11'(XMAX);
    localparam logic [10:0]         YEXIT_W  = 11'(YEXIT);
    localparam logic [COORD_W-1:0]  XMIN_C   = COORD_W'(XMIN);
    localparam logic [COORD_W-1:0]  YSPAWN_C = COORD_W'(YSPAWN);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  spawn_cnt_q, spawn_cnt_d;
    logic [N_AST-1:0]  hit_l_q, hit_l_d;
    logic              score_q, score_d;
    logic              kill_q, kill_d;
    logic              ovr_q, ovr_d;
    slot_t             slots_q [N_AST];
    slot_t             slots_d [N_AST];

    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_unused;
    slot_t             cur;
    logic [10:0]       ysum;
    logic signed [10:0] xsum;
    logic [N_AST-1:0]  act_vec;
    logic              free_found;
    logic [IDX_W-1:0]  free_idx;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (pixpulse),
        .state (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:13];

    always_comb begin
        act_vec    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < N_AST; i++) begin
            act_vec[i] = slots_q[i].active;
        end
        // Descending scan so the lowest-index free slot is the one kept
        for (int i = N_AST - 1; i >= 0; i--) begin
            if (!slots_q[i].active) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        spawn_cnt_d = spawn_cnt_q;
        hit_l_d     = hit_l_q;
        score_d     = 1'b0;
        kill_d      = 1'b0;
        ovr_d       = ovr_q;
        slots_d     = slots_q;

        cur  = slots_q[idx_q];
        ysum = {1'b0, cur.y} + {8'b0, cur.vspd};
        xsum = $signed({1'b0, cur.x}) + $signed({{8{cur.hspd[2]}}, cur.hspd});

        case (state_q)
            IDLE: begin
                if (frame_tick && enable) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (frame_tick) begin
                    ovr_d = 1'b1;
                end
                if (cur.active) begin
                    hit_l_d[idx_q] = 1'b0;
                    if (hit_l_q[idx_q]) begin
                        slots_d[idx_q].active = 1'b0;
                        kill_d                = 1'b1;
                    end else begin
                        slots_d[idx_q].y = ysum[COORD_W-1:0];
                        if (ysum >= YEXIT_W) begin
                            slots_d[idx_q].active = 1'b0;
                            score_d               = 1'b1;
                        end else if (xsum < XMIN_S || xsum > XMAX_S) begin
                            slots_d[idx_q].hspd = ~cur.hspd + 3'sd1;
                        end else begin
                            slots_d[idx_q].x = xsum[COORD_W-1:0];
                        end
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = SPAWN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            SPAWN: begin
                if (frame_tick) begin
                    ovr_d = 1'b1;
                end
                if (spawn_cnt_q == '0) begin
                    if (free_found) begin
                        slots_d[free_idx].active = 1'b1;
                        slots_d[free_idx].x      = XMIN_C + {1'b0, lfsr[8:0]};
                        slots_d[free_idx].y      = YSPAWN_C;
                        slots_d[free_idx].vspd   = {1'b0, lfsr[10:9]} + 3'd1;
                        slots_d[free_idx].hspd   = {lfsr[12], lfsr[12:11]};
                        hit_l_d[free_idx]        = 1'b0;
                        spawn_cnt_d              = CNT_LOAD;
                    end
                end else begin
                    spawn_cnt_d = spawn_cnt_q - 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new hit is recorded after the processing clear so it is never lost
        hit_l_d = hit_l_d | (hit & act_vec & {N_AST{enable}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            spawn_cnt_q <= '0;
            hit_l_q     <= '0;
            score_q     <= 1'b0;
            kill_q      <= 1'b0;
            ovr_q       <= 1'b0;
            for (int i = 0; i < N_AST; i++) begin
                slots_q[i] <= '0;
            end
        end else if (pixpulse) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            spawn_cnt_q <= spawn_cnt_d;
            hit_l_q     <= hit_l_d;
            score_q     <= score_d;
            kill_q      <= kill_d;
            ovr_q       <= ovr_d;
            for (int i = 0; i < N_AST; i++) begin
                slots_q[i] <= slots_d[i];
            end
        end
    end

    always_comb begin
        xloc = '0;
        yloc = '0;
        for (int i = 0; i < N_AST; i++) begin
            xloc[COORD_W*i +: COORD_W] = slots_q[i].x;
            yloc[COORD_W*i +: COORD_W] = slots_q[i].y;
        end
    end

    assign active    = act_vec;
    assign score_inc = score_q;
    assign kill_inc  = kill_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/asteroid_wave_ctrl.md
Name: asteroid_wave_ctrl

Overview:
- Scheduler for the falling-asteroid field. Owns N asteroid slots and, once per frame, sequences a position update for every active slot.
- Retires slots that are hit or leave the screen, and spawns new asteroids at pseudo-random x positions and speeds.
- Sits between the VGA timing/move-pulse logic and the per-asteroid draw/collision logic. Emits serialized score and kill events to the score block.

Parameters:
- N_AST, 4, number of asteroid slots (1..8).
- XMIN, 10, leftmost legal x.
- XMAX, 610, rightmost legal x; XMAX-XMIN must be >= 511.
- YSPAWN, 10, spawn y.
- YEXIT, 480, y at or beyond which an asteroid has exited.
- SPAWN_GAP, 30, frames between spawn attempts.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- pixpulse  in  1  clock enable; all state updates only on clk edges with pixpulse=1.
- frame_tick  in  1  start-of-update request, one pixpulse period per frame.
- enable  in  1  game running; 0 freezes the field.
- hit  in  N_AST  per-slot collision indication from the draw/collision logic.
- active  out  N_AST  slot occupied.
- xloc  out  10*N_AST  packed x positions; slot i at [10i+9:10i].
- yloc  out  10*N_AST  packed y positions.
- score_inc  out  1  one pixpulse period: asteroid exited the bottom.
- kill_inc  out  1  one pixpulse period: asteroid destroyed by a hit.
- overrun  out  1  sticky: a frame_tick arrived while not IDLE.

Behaviour:
- Reset:
  - active=0, all xloc/yloc=0, speeds=0, score_inc=kill_inc=overrun=0.
  - hit latches cleared, spawn_cnt=0, LFSR=LFSR_SEED, FSM=IDLE.
  - Reset asserted mid-UPDATE aborts the pass; no pulses are emitted.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every pixpulse regardless of state.
- Hit latch: hit[i] & active[i] & enable sets hit_l[i]. hit_l[i] is cleared when slot i is processed in UPDATE. hit on an inactive slot is ignored.
- FSM states: IDLE, UPDATE, SPAWN.
  - IDLE: frame_tick & enable -> UPDATE with idx=0. frame_tick with enable=0 is ignored.
  - UPDATE: processes slot idx, one slot per pixpulse.
    - Inactive slot: no change.
    - hit_l set: active<=0, kill_inc<=1. Hit wins over a simultaneous exit.
    - Otherwise y<=y+vspd. If y+vspd >= YEXIT: active<=0, score_inc<=1.
    - Otherwise x<=x+hspd (signed). If the result is < XMIN or > XMAX: x is left unchanged and the sign of hspd is inverted (reflect).
    - idx==N_AST-1 -> SPAWN; else idx++.
  - SPAWN:
    - If spawn_cnt==0 and any slot is free: the lowest-index free slot gets active=1, x=XMIN+lfsr[8:0], y=YSPAWN, vspd=lfsr[10:9]+1 (range 1..4), hspd=signed lfsr[12:11] (range -2..+1). spawn_cnt<=SPAWN_GAP-1.
    - Else if spawn_cnt!=0: spawn_cnt--.
    - All slots full with spawn_cnt==0: hold at 0 and retry next frame.
    - -> IDLE.
- Latency: frame_tick to the last position write is N_AST pixpulse periods; IDLE is re-entered after N_AST+1.
- score_inc and kill_inc each last exactly one pixpulse period. At most one event is emitted per pixpulse period, so events are serialized by slot order.
- Widths: x and y are 10-bit unsigned; arithmetic is 11-bit internally to detect overflow; hspd is 3-bit signed; vspd is 3-bit unsigned.
- overrun sets on frame_tick in UPDATE or SPAWN; that tick is dropped. overrun is cleared only by rst.
- enable falling mid-pass: the pass completes; later frame_ticks are ignored until enable returns.

Decomposition:
- Package asteroid_pkg: COORD_W=10, state enum {IDLE,UPDATE,SPAWN}, LFSR tap constants, slot record typedef {active, x, y, hspd, vspd}.
- One sub-module: lfsr16 (seed parameter, enable input, 16-bit state output).

Test Plan:
- Reset, enable=1, frame_tick -> after 5 pixpulses active=4'b0001, yloc[0]=10, XMIN<=xloc[0]<=521, no score_inc/kill_inc.
- Slot 0 at y=476, vspd=4, no hit; frame_tick -> active[0]=0, exactly one score_inc pulse, kill_inc=0.
- hit[0] pulsed mid-frame with slot 0 at y=476, vspd=4 -> next pass gives kill_inc=1, score_inc=0, active[0]=0.
- Slot at x=609, hspd=+1 -> x becomes 610. Next frame: 611 > XMAX, so x stays 610 and hspd=-1. Following frame: x=609.
- Two asteroids exit in the same frame (slots 1 and 3) -> two score_inc pulses in consecutive-slot order: pulse at UPDATE idx=1, then at idx=3.
- frame_tick reasserted 2 pixpulses after a first tick -> overrun=1, pass count unchanged. Separately, SPAWN_GAP=30: spawns occur on frames 0, 30, 60 while slots are free. With all 4 slots full, no spawn; a spawn occurs in the first frame after a slot frees.
